// File: rtl/st2bus_pack_if.sv
// st2bus_pack_if: groups the byte-stream side and the bus-word side of the
// packer into one bundle.
//   st_data/st_valid/st_sop/st_eop  -> packer (Avalon-ST bytes)
//   st_ready                        <- packer
//   bus_data/bus_en                 <- packer (534-bit words)
//   bus_ready                       -> packer
//   drop                            <- packer (discarded-byte pulse)
// slave is the packer's view; master is the view of whatever drives the
// stream and sinks the bus words.
interface st2bus_pack_if;
    localparam int BUS = 534;

    logic [7:0]     st_data;
    logic           st_valid;
    logic           st_sop;
    logic           st_eop;
    logic           st_ready;
    logic [BUS-1:0] bus_data;
    logic           bus_en;
    logic           bus_ready;
    logic           drop;

    modport master (
        output st_data, st_valid, st_sop, st_eop, bus_ready,
        input  st_ready, bus_data, bus_en, drop
    );

    modport slave (
        input  st_data, st_valid, st_sop, st_eop, bus_ready,
        output st_ready, bus_data, bus_en, drop
    );
endinterface

// File: rtl/st2bus_pack.sv
// st2bus_pack: packs the 8-bit decoded-bit stream into 534-bit bus words
// (512-bit payload + 22-bit header) with one accumulator word and one output
// word of buffering.
//   clk  single clock
//   rst  synchronous, active-high reset
//   io   st2bus_pack_if.slave: byte stream in, bus words out, drop pulse
// Header: [518:512] count, [519] sop_word, [520] eop_word, [528:521] seq,
//         [529] err, [533:530] zero.
// Build option: define ST2BUS_SEQ_EN to carry the running packet counter in
// the seq field; otherwise seq is constant zero and the counter is absent.
module st2bus_pack (
    input  logic         clk,
    input  logic         rst,
    st2bus_pack_if.slave io
);
    typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

    state_t           state, state_n;
    logic [63:0][7:0] acc_data, acc_data_n;
    logic [5:0]       idx, idx_n;
    logic             acc_sop, acc_sop_n;
    logic             acc_done, acc_done_n;
    logic [21:0]      acc_hdr, acc_hdr_n;
    logic [533:0]     bus_data, bus_data_n;
    logic             bus_en, bus_en_n;
    logic             drop, drop_n;
    logic [7:0]       seq_old, seq_new;

    logic             out_free, split, fire;
    logic [63:0][7:0] word;
    logic [5:0]       wr_idx;
    logic             sop_w, done_w;
    logic [21:0]      cmp_hdr;

    function automatic logic [21:0] hdr(input logic [6:0] cnt, input logic sop_word,
                                        input logic eop_word, input logic [7:0] sq,
                                        input logic err);
        return {4'b0000, err, sq, eop_word, sop_word, cnt};
    endfunction

    assign out_free = !bus_en || io.bus_ready;
    // sop landing on a partially filled word forces that word out first
    assign split    = io.st_valid && io.st_sop && (state == PKT) && (idx != 6'd0);
    // a split needs the output register this cycle; if it is busy the partial
    // word is parked in the accumulator and the sop byte waits
    assign io.st_ready = !rst && !acc_done && !(split && !out_free);
    assign fire     = io.st_valid && io.st_ready;

`ifdef ST2BUS_SEQ_EN
    logic [7:0] seq;
    logic [1:0] seq_adv;
    // packets closed this cycle: a truncation (parked or in-line) and/or an eop
    assign seq_adv = 2'(!acc_done && split && !out_free)
                   + 2'(fire && (state == PKT) && io.st_sop)
                   + 2'(fire && io.st_eop && ((state == PKT) || io.st_sop));
    always_ff @(posedge clk) begin
        if (rst) seq <= 8'd0;
        else     seq <= seq + {6'd0, seq_adv};
    end
    assign seq_old = seq;
    // sop inside an open packet starts the next packet number
    assign seq_new = seq + {7'd0, (state == PKT) && io.st_sop};
`else
    assign seq_old = 8'd0;
    assign seq_new = 8'd0;
`endif

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        acc_data_n = acc_data;
        acc_sop_n  = acc_sop;
        acc_done_n = acc_done;
        acc_hdr_n  = acc_hdr;
        bus_data_n = bus_data;
        bus_en_n   = bus_en && !io.bus_ready;
        drop_n     = 1'b0;
        word       = acc_data;
        wr_idx     = idx;
        sop_w      = acc_sop;
        done_w     = 1'b0;
        cmp_hdr    = '0;
        if (acc_done) begin
            if (out_free) begin
                bus_data_n = {acc_hdr, acc_data};
                bus_en_n   = 1'b1;
                acc_done_n = 1'b0;
                acc_data_n = '0;
            end
        end else if (split && !out_free) begin
            acc_hdr_n  = hdr({1'b0, idx}, acc_sop, 1'b1, seq_old, 1'b1);
            acc_done_n = 1'b1;
            idx_n      = 6'd0;
            acc_sop_n  = 1'b0;
            state_n    = IDLE;
        end else if (fire) begin
            if (state == IDLE && !io.st_sop) begin
                drop_n = 1'b1;
            end else begin
                if (split) begin
                    bus_data_n = {hdr({1'b0, idx}, acc_sop, 1'b1, seq_old, 1'b1), acc_data};
                    bus_en_n   = 1'b1;
                end
                if (io.st_sop) begin
                    word   = '0;
                    wr_idx = 6'd0;
                    sop_w  = 1'b1;
                end
                word[wr_idx] = io.st_data;
                done_w  = (wr_idx == 6'd63) || io.st_eop;
                cmp_hdr = hdr({1'b0, wr_idx} + 7'd1, sop_w, io.st_eop, seq_new, 1'b0);
                if (done_w) begin
                    // after a split the output register is already taken
                    if (out_free && !split) begin
                        bus_data_n = {cmp_hdr, word};
                        bus_en_n   = 1'b1;
                        acc_data_n = '0;
                    end else begin
                        acc_hdr_n  = cmp_hdr;
                        acc_data_n = word;
                        acc_done_n = 1'b1;
                    end
                    idx_n     = 6'd0;
                    acc_sop_n = 1'b0;
                    state_n   = io.st_eop ? IDLE : PKT;
                end else begin
                    acc_data_n = word;
                    idx_n      = wr_idx + 6'd1;
                    acc_sop_n  = sop_w;
                    state_n    = PKT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 6'd0;
            acc_data <= '0;
            acc_sop  <= 1'b0;
            acc_done <= 1'b0;
            acc_hdr  <= '0;
            bus_data <= '0;
            bus_en   <= 1'b0;
            drop     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            acc_data <= acc_data_n;
            acc_sop  <= acc_sop_n;
            acc_done <= acc_done_n;
            acc_hdr  <= acc_hdr_n;
            bus_data <= bus_data_n;
            bus_en   <= bus_en_n;
            drop     <= drop_n;
        end
    end

    assign io.bus_data = bus_data;
    assign io.bus_en   = bus_en;
    assign io.drop     = drop;
endmodule

// File: tb/tb_st2bus_pack.sv
// tb_st2bus_pack: directed scenarios plus randomized packets for st2bus_pack,
// checked against a byte-queue packet model.
module tb_st2bus_pack;
    logic clk = 1'b0;
    logic rst;
    st2bus_pack_if io();
    st2bus_pack dut (.clk(clk), .rst(rst), .io(io));
    always #5 clk = ~clk;

    int           checks   = 0;
    int           failures = 0;
    logic [533:0] exp_q[$];
    logic [533:0] got[$];
    logic [7:0]   cur[$];
    logic         open    = 1'b0;
    logic         cur_sop = 1'b0;
    int           seq     = 0;
    logic         exp_drop = 1'b0;
    int           rdy_mode = 1;

    function automatic int exp_seq(input int s);
`ifdef ST2BUS_SEQ_EN
        return s % 256;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [533:0] obs, input logic [533:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_hdr(input string tag, input logic [533:0] w, input int cnt,
                             input logic s, input logic e, input int sq, input logic err);
        check(tag, w[533:512], {4'b0, err, 8'(exp_seq(sq)), e, s, 7'(cnt)});
    endtask

    task automatic emit(input logic e, input logic err);
        logic [533:0] w;
        w = '0;
        foreach (cur[k]) w[8*k +: 8] = cur[k];
        w[533:512] = {4'b0, err, 8'(exp_seq(seq)), e, cur_sop, 7'(cur.size())};
        exp_q.push_back(w);
    endtask

    // packet rules applied to each accepted byte
    task automatic model_byte(input logic [7:0] d, input logic s, input logic e);
        if (!open && !s) begin
            exp_drop = 1'b1;
            return;
        end
        if (open && s) begin
            if (cur.size() > 0) emit(1'b1, 1'b1);
            seq = (seq + 1) % 256;
            cur.delete();
            cur_sop = 1'b0;
        end
        if (s) begin
            open    = 1'b1;
            cur_sop = 1'b1;
        end
        cur.push_back(d);
        if (cur.size() == 64 || e) begin
            emit(e, 1'b0);
            cur.delete();
            cur_sop = 1'b0;
            if (e) begin
                open = 1'b0;
                seq  = (seq + 1) % 256;
            end
        end
    endtask

    task automatic model_reset();
        cur.delete();
        exp_q.delete();
        open     = 1'b0;
        cur_sop  = 1'b0;
        seq      = 0;
        exp_drop = 1'b0;
    endtask

    // one cycle: drive after negedge, sample 1 time unit later, then clock
    task automatic cyc(input logic v, input logic [7:0] d, input logic s, input logic e,
                       output logic acc);
        logic rdy;
        rdy = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
        io.st_valid  = v;
        io.st_data   = d;
        io.st_sop    = s;
        io.st_eop    = e;
        io.bus_ready = rdy;
        #1;
        check("drop", io.drop, exp_drop);
        exp_drop = 1'b0;
        acc = v && io.st_ready;
        if (acc) model_byte(d, s, e);
        if (io.bus_en) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL bus_en_no_word observed=1 expected=0");
            end
            if (exp_q.size() > 0) begin
                check("bus_data", io.bus_data, exp_q[0]);
                if (rdy) begin
                    got.push_back(io.bus_data);
                    void'(exp_q.pop_front());
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && n < 2000) begin
            cyc(1'b1, d, s, e, a);
            n++;
        end
        if (!a) check("send_timeout", a, 1'b1);
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) cyc(1'b0, 8'(($urandom)), 1'b0, 1'b0, a);
    endtask

    task automatic drain();
        logic a;
        int   n;
        int   save;
        save = rdy_mode;
        rdy_mode = 1;
        n = 0;
        while ((exp_q.size() != 0 || io.bus_en) && n < 1000) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0, a);
            n++;
        end
        check("drain_empty", 534'(exp_q.size()), 534'd0);
        rdy_mode = save;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           base;
        int           n;
        int           len;
        logic         a;
        logic [533:0] w;

        rst = 1'b1;
        io.st_valid = 1'b0; io.st_data = 8'h00; io.st_sop = 1'b0; io.st_eop = 1'b0;
        io.bus_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_st_ready", io.st_ready, 1'b0);
        check("rst_bus_en", io.bus_en, 1'b0);
        check("rst_bus_data", io.bus_data, '0);
        check("rst_drop", io.drop, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_st_ready", io.st_ready, 1'b1);

        // 128-byte packet -> two full words
        base = got.size();
        for (int i = 0; i < 128; i++) send_byte(8'(i), i == 0, i == 127);
        drain();
        check("p128_words", 534'(got.size() - base), 534'd2);
        if (got.size() >= base + 2) begin
            check_hdr("p128_w0_hdr", got[base], 64, 1'b1, 1'b0, 0, 1'b0);
            check("p128_w0_b0", got[base][7:0], 8'h00);
            check_hdr("p128_w1_hdr", got[base+1], 64, 1'b0, 1'b1, 0, 1'b0);
            check("p128_w1_b63", got[base+1][511:504], 8'h7F);
        end

        // 3-byte packet; word appears right after the eop edge
        send_byte(8'hA1, 1'b1, 1'b0);
        send_byte(8'hB2, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b1);
        w = '0;
        w[23:0] = 24'hC3B2A1;
        w[533:512] = {4'b0, 1'b0, 8'(exp_seq(1)), 1'b1, 1'b1, 7'd3};
        check("p3_latency_en", io.bus_en, 1'b1);
        check("p3_word", io.bus_data, w);
        drain();

        // stray bytes before any sop: drop pulses, no words
        base = got.size();
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b1);
        send_byte(8'h33, 1'b0, 1'b0);
        idle(2);
        check("stray_no_word", 534'(got.size() - base), 534'd0);

        // sop at idx 10 truncates the open packet
        base = got.size();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), i == 0, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h90 + i), i == 0, i == 4);
        drain();
        check("trunc_words", 534'(got.size() - base), 534'd2);
        if (got.size() >= base + 2) begin
            check_hdr("trunc_w0_hdr", got[base], 10, 1'b1, 1'b1, 2, 1'b1);
            check_hdr("trunc_w1_hdr", got[base+1], 5, 1'b1, 1'b1, 3, 1'b0);
            check("trunc_w1_b0", got[base+1][7:0], 8'h90);
        end

        // 256-byte stream against a stalled bus
        base = got.size();
        rdy_mode = 0;
        n = 0;
        for (int c = 0; c < 200; c++) begin
            cyc(1'b1, 8'(n * 3), n == 0, n == 255, a);
            if (a) n++;
        end
        check("bp_accepted", 534'(n), 534'd128);
        check("bp_st_ready_low", io.st_ready, 1'b0);
        rdy_mode = 1;
        while (n < 256) begin
            send_byte(8'(n * 3), n == 0, n == 255);
            n++;
        end
        drain();
        check("bp_words", 534'(got.size() - base), 534'd4);

        // reset with 40 bytes in the accumulator
        for (int i = 0; i < 40; i++) send_byte(8'(i + 5), i == 0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_st_ready", io.st_ready, 1'b0);
        idle(2);
        rst = 1'b0;
        #1;
        check("mid_rst_bus_en", io.bus_en, 1'b0);
        check("mid_rst_st_ready_after", io.st_ready, 1'b1);
        base = got.size();
        for (int i = 0; i < 4; i++) send_byte(8'(8'hE0 + i), i == 0, i == 3);
        drain();
        check("mid_rst_words", 534'(got.size() - base), 534'd1);
        if (got.size() >= base + 1) begin
            check_hdr("mid_rst_hdr", got[base], 4, 1'b1, 1'b1, 0, 1'b0);
            check("mid_rst_b0", got[base][7:0], 8'hE0);
        end

        // randomized packets, truncations, strays and bus stalls
        rdy_mode = 2;
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(0, 7) == 0) send_byte(8'($urandom), 1'b0, 1'b0);
            len = $urandom_range(1, 140);
            if ($urandom_range(0, 5) == 0) begin
                for (int i = 0; i < len; i++) begin
                    send_byte(8'($urandom), i == 0, 1'b0);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
            end else begin
                for (int i = 0; i < len; i++) begin
                    send_byte(8'($urandom), i == 0, i == len - 1);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
            end
        end
        send_byte(8'h5A, 1'b1, 1'b1);
        drain();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
